// File: rtl/single_conv2d.sv
// -----------------------------------------------------------------------------
// single_conv2d
//   Self-contained 2D convolution engine. A fixed KxK kernel slides over a
//   fixed IMG_H x IMG_W image held in constant storage, with stride 1 and no
//   padding. Each enabled clock produces one output pixel, in raster order.
//   After the last window the sequence wraps back to window (0,0).
//
// Ports
//   clk     : system clock, rising edge
//   rst_n   : asynchronous active-low reset (out_pix = 0, window = (0,0))
//   en      : high = compute the current window and advance the index
//   out_pix : registered result of the most recent window, saturated to OUT_W
//
// Parameters IMG_FILL / KERN_FILL: 0 selects the normal generated contents
// (img(r,c) = IMG_W*r + c + 1, k(i,j) = K*i + j + 1). A nonzero value replaces
// every element with that constant, which is used to exercise saturation.
// -----------------------------------------------------------------------------
module single_conv2d #(
    parameter int IMG_W     = 5,
    parameter int IMG_H     = 5,
    parameter int K         = 3,
    parameter int DATA_W    = 8,
    parameter int OUT_W     = 16,
    parameter int IMG_FILL  = 0,
    parameter int KERN_FILL = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output logic [OUT_W-1:0]  out_pix
);

    localparam int OUT_HD = IMG_H - K + 1;
    localparam int OUT_WD = IMG_W - K + 1;
    localparam int ROW_W  = (OUT_HD > 1) ? $clog2(OUT_HD) : 1;
    localparam int COL_W  = (OUT_WD > 1) ? $clog2(OUT_WD) : 1;
    localparam int NPIX   = IMG_H * IMG_W;
    localparam int NKER   = K * K;
    localparam int IDX_W  = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int KIDX_W = (NKER > 1) ? $clog2(NKER) : 1;
    localparam int PROD_W = 2 * DATA_W;
    localparam int ACC_W  = 2 * DATA_W + 4;

    // Constant image and kernel, stored row-major. Since the generator is
    // W*r + c + 1, the flat row-major element value is simply index + 1.
    logic [DATA_W-1:0] img_rom  [NPIX];
    logic [DATA_W-1:0] kern_rom [NKER];

    genvar gi;
    generate
        for (gi = 0; gi < NPIX; gi++) begin : g_img
            assign img_rom[gi] = (IMG_FILL != 0) ? DATA_W'(IMG_FILL) : DATA_W'(gi + 1);
        end
        for (gi = 0; gi < NKER; gi++) begin : g_kern
            assign kern_rom[gi] = (KERN_FILL != 0) ? DATA_W'(KERN_FILL) : DATA_W'(gi + 1);
        end
    endgenerate

    logic [ROW_W-1:0] orow_q, orow_d;
    logic [COL_W-1:0] ocol_q, ocol_d;
    logic [OUT_W-1:0] out_q, out_d;
    logic [ACC_W-1:0] acc;
    logic [PROD_W-1:0] prod;

    // Full KxK multiply-accumulate for the current window, one cycle.
    always_comb begin
        acc  = '0;
        prod = '0;
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
                prod = {{DATA_W{1'b0}}, kern_rom[KIDX_W'(i * K + j)]}
                     * {{DATA_W{1'b0}},
                        img_rom[IDX_W'((int'(orow_q) + i) * IMG_W + int'(ocol_q) + j)]};
                acc  = acc + {{(ACC_W - PROD_W){1'b0}}, prod};
            end
        end
    end

    // Next-state: advance raster index and capture saturated result when enabled.
    always_comb begin
        orow_d = orow_q;
        ocol_d = ocol_q;
        out_d  = out_q;
        if (en) begin
            // Any set bit above OUT_W means acc exceeds the output range.
            out_d = (|acc[ACC_W-1:OUT_W]) ? {OUT_W{1'b1}} : acc[OUT_W-1:0];
            if (ocol_q == COL_W'(OUT_WD - 1)) begin
                ocol_d = '0;
                orow_d = (orow_q == ROW_W'(OUT_HD - 1)) ? '0 : orow_q + 1'b1;
            end else begin
                ocol_d = ocol_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            orow_q <= '0;
            ocol_q <= '0;
            out_q  <= '0;
        end else begin
            orow_q <= orow_d;
            ocol_q <= ocol_d;
            out_q  <= out_d;
        end
    end

    assign out_pix = out_q;

endmodule

// File: tb/tb_single_conv2d.sv
module tb_single_conv2d;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [15:0] out_pix;
    logic [15:0] out_sat;

    int checks   = 0;
    int failures = 0;

    single_conv2d dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .out_pix (out_pix)
    );

    single_conv2d #(.IMG_FILL(255), .KERN_FILL(255)) dut_sat (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .out_pix (out_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: window value computed directly from the image/kernel formulas.
    function automatic int ref_window(input int idx, input int img_fill, input int k_fill);
        int r, c, acc, iv, kv;
        r   = idx / 3;
        c   = idx % 3;
        acc = 0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                iv  = (img_fill != 0) ? img_fill : ((5 * (r + i) + (c + j) + 1) & 255);
                kv  = (k_fill != 0) ? k_fill : ((3 * i + j + 1) & 255);
                acc = acc + iv * kv;
            end
        end
        return (acc > 65535) ? 65535 : acc;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    // One clock: drive en away from the edge, sample 1 time unit after the edge.
    task automatic cycle(input logic e);
        en = e;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
    endtask

    typedef struct {
        bit pre_rst;
        bit en;
        int exp;
    } vec_t;

    vec_t tbl[24];

    int widx;
    int exp_out;
    int exp_sat;
    bit sat_emitted;

    initial begin
        // Continuous run + wrap (15 edges), then reset and stall sequence.
        tbl[0]  = '{0, 1, 411};  tbl[1]  = '{0, 1, 456};  tbl[2]  = '{0, 1, 501};
        tbl[3]  = '{0, 1, 636};  tbl[4]  = '{0, 1, 681};  tbl[5]  = '{0, 1, 726};
        tbl[6]  = '{0, 1, 861};  tbl[7]  = '{0, 1, 906};  tbl[8]  = '{0, 1, 951};
        tbl[9]  = '{0, 1, 411};  tbl[10] = '{0, 1, 456};  tbl[11] = '{0, 1, 501};
        tbl[12] = '{0, 1, 636};  tbl[13] = '{0, 1, 681};  tbl[14] = '{0, 1, 726};
        tbl[15] = '{1, 1, 411};  tbl[16] = '{0, 1, 456};  tbl[17] = '{0, 1, 501};
        tbl[18] = '{0, 0, 501};  tbl[19] = '{0, 0, 501};  tbl[20] = '{0, 0, 501};
        tbl[21] = '{0, 0, 501};  tbl[22] = '{0, 1, 636};  tbl[23] = '{0, 1, 681};

        rst_n = 1'b0;
        en    = 1'b0;

        // Reset then idle.
        for (int n = 0; n < 2; n++) begin
            cycle(1'b0);
            check($sformatf("reset_hold[%0d]", n), out_pix, 0);
        end
        rst_n = 1'b1;
        for (int n = 0; n < 5; n++) begin
            cycle(1'b0);
            check($sformatf("idle[%0d]", n), out_pix, 0);
        end
        check("idle_sat", out_sat, 0);

        // Table-driven sequence.
        foreach (tbl[n]) begin
            if (tbl[n].pre_rst) pulse_reset();
            cycle(tbl[n].en);
            check($sformatf("vec[%0d]", n), out_pix, tbl[n].exp);
        end

        // Asynchronous reset between edges: output clears with no clock.
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_out", out_pix, 0);
        check("async_rst_sat", out_sat, 0);
        #1 rst_n = 1'b1;
        cycle(1'b0);
        check("after_rst_idle", out_pix, 0);
        cycle(1'b1);
        check("after_rst_first", out_pix, 411);

        // Saturation: all-255 image and kernel.
        check("sat_first", out_sat, ref_window(0, 255, 255));
        check("sat_allones", out_sat, 16'hFFFF);

        // Randomized enable pattern against the reference model.
        pulse_reset();
        widx        = 0;
        exp_out     = 0;
        sat_emitted = 1'b0;
        for (int n = 0; n < 80; n++) begin
            logic e;
            e = 1'($urandom_range(0, 1));
            cycle(e);
            if (e) begin
                exp_out     = ref_window(widx, 0, 0);
                widx        = (widx + 1) % 9;
                sat_emitted = 1'b1;
            end
            exp_sat = sat_emitted ? ref_window(0, 255, 255) : 0;
            check($sformatf("rand[%0d] en=%0d", n, e), out_pix, exp_out);
            check($sformatf("rand_sat[%0d]", n), out_sat, exp_sat);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
